// File: rtl/esfa_request_arbiter_if.sv
// Bundle between NUM_REQ requesters, the arbiter and one ESFADesign datapath.
// Latency: none, wires only. Backpressure: req_valid/req_ready per requester slot.
// Ports: req_* (per-slot op, 8-bit fields packed slot i at [8i+7:8i]), esfa_* (datapath side),
//        rsp_* (one-hot result return), busy. slave = arbiter view, master = requester/datapath view.
interface esfa_request_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_mutate;
  logic [8*NUM_REQ-1:0] req_index;
  logic [8*NUM_REQ-1:0] req_value;
  logic [8*NUM_REQ-1:0] req_metadata;
  logic [NUM_REQ-1:0]   req_is_metadata;
  logic [8*NUM_REQ-1:0] req_selector;

  logic [7:0]           esfa_new_index;
  logic [7:0]           esfa_new_value;
  logic [7:0]           esfa_metadata;
  logic                 esfa_is_metadata;
  logic [7:0]           esfa_selector;
  logic                 esfa_write_en;
  logic                 esfa_issue;
  logic                 esfa_result_bool;
  logic [7:0]           esfa_result_value;

  logic [NUM_REQ-1:0]   rsp_valid;
  logic                 rsp_bool;
  logic [7:0]           rsp_value;
  logic                 busy;

  modport slave (
    input  req_valid, req_mutate, req_index, req_value, req_metadata,
           req_is_metadata, req_selector, esfa_result_bool, esfa_result_value,
    output req_ready, esfa_new_index, esfa_new_value, esfa_metadata,
           esfa_is_metadata, esfa_selector, esfa_write_en, esfa_issue,
           rsp_valid, rsp_bool, rsp_value, busy
  );

  modport master (
    output req_valid, req_mutate, req_index, req_value, req_metadata,
           req_is_metadata, req_selector, esfa_result_bool, esfa_result_value,
    input  req_ready, esfa_new_index, esfa_new_value, esfa_metadata,
           esfa_is_metadata, esfa_selector, esfa_write_en, esfa_issue,
           rsp_valid, rsp_bool, rsp_value, busy
  );
endinterface

// File: rtl/esfa_request_arbiter.sv
// Round-robin arbiter + sequencer sharing one ESFADesign among NUM_REQ requesters.
// Latency: transfer at T, esfa_issue at T+1, rsp_valid at T+2+RESULT_LATENCY; one op in flight.
// Backpressure: req_ready is a combinational one-hot grant only in IDLE; 0 while busy.
// Ports: clk, reset (synchronous, active-low), bus (esfa_request_arbiter_if.slave).
module esfa_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int RESULT_LATENCY = 2
) (
  input logic                   clk,
  input logic                   reset,
  esfa_request_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RESULT_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr, ptr_nxt, owner;
  logic [IW-1:0] grant_id, hi_id, lo_id;
  logic          hi_found, lo_found;
  logic          transfer, wait_done;
  logic [CW-1:0] wait_cnt;

  logic [7:0]    sel_index, sel_value, sel_metadata, sel_selector;
  logic          sel_mutate, sel_is_metadata;

  logic [7:0]    index_q, value_q, metadata_q, selector_q;
  logic          is_metadata_q, mutate_q;
  logic          rsp_bool_q;
  logic [7:0]    rsp_value_q;

  // Round-robin search: lowest valid index at or above rr_ptr wins; if none
  // exists the lowest valid index overall wins (the wrap-around case).
  // Iterating downward lets the last hit be the lowest index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_id    = IW'(i);
        if (IW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_id    = IW'(i);
        end
      end
    end
    grant_id = hi_found ? hi_id : lo_id;
  end

  assign transfer  = reset && (state == IDLE) && lo_found;
  assign ptr_nxt   = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign wait_done = (state == WAIT) && (wait_cnt == CW'(RESULT_LATENCY - 1));

  // Operand mux for the granted slot.
  always_comb begin
    sel_index       = '0;
    sel_value       = '0;
    sel_metadata    = '0;
    sel_selector    = '0;
    sel_mutate      = 1'b0;
    sel_is_metadata = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        sel_index       = bus.req_index[8*i +: 8];
        sel_value       = bus.req_value[8*i +: 8];
        sel_metadata    = bus.req_metadata[8*i +: 8];
        sel_selector    = bus.req_selector[8*i +: 8];
        sel_mutate      = bus.req_mutate[i];
        sel_is_metadata = bus.req_is_metadata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.esfa_issue    = 1'b0;
    bus.esfa_write_en = 1'b0;
    bus.rsp_valid     = '0;
    bus.busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (transfer) begin
          bus.req_ready = NUM_REQ'(1) << grant_id;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        bus.esfa_issue    = 1'b1;
        bus.esfa_write_en = mutate_q;
        state_nxt         = WAIT;
      end
      WAIT: begin
        if (wait_done) state_nxt = RESPOND;
      end
      RESPOND: begin
        bus.rsp_valid = NUM_REQ'(1) << owner;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr        <= '0;
      owner         <= '0;
      wait_cnt      <= '0;
      index_q       <= '0;
      value_q       <= '0;
      metadata_q    <= '0;
      selector_q    <= '0;
      is_metadata_q <= 1'b0;
      mutate_q      <= 1'b0;
      rsp_bool_q    <= 1'b0;
      rsp_value_q   <= '0;
    end else begin
      if (transfer) begin
        rr_ptr        <= ptr_nxt;
        owner         <= grant_id;
        index_q       <= sel_index;
        value_q       <= sel_value;
        metadata_q    <= sel_metadata;
        selector_q    <= sel_selector;
        is_metadata_q <= sel_is_metadata;
        mutate_q      <= sel_mutate;
      end
      if (state == WAIT) begin
        if (wait_done) begin
          wait_cnt    <= '0;
          // Mutates return a bare completion ack, so results are zeroed.
          rsp_bool_q  <= mutate_q ? 1'b0 : bus.esfa_result_bool;
          rsp_value_q <= mutate_q ? 8'h00 : bus.esfa_result_value;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.esfa_new_index   = index_q;
  assign bus.esfa_new_value   = value_q;
  assign bus.esfa_metadata    = metadata_q;
  assign bus.esfa_is_metadata = is_metadata_q;
  assign bus.esfa_selector    = selector_q;
  assign bus.rsp_bool         = rsp_bool_q;
  assign bus.rsp_value        = rsp_value_q;
endmodule

// File: tb/tb_esfa_request_arbiter.sv
// Testbench for esfa_request_arbiter (NUM_REQ=4, RESULT_LATENCY=2).
// Directed ops push hand-computed expectations; negedge monitors pop and compare
// grants, issued operands and responses. ESFA model: result = (sel[0], sel ^ 8'h2F),
// presented only in the cycle RESULT_LATENCY after esfa_issue, garbage otherwise.
module tb_esfa_request_arbiter;
  localparam int NUM_REQ = 4;
  localparam int RL      = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  esfa_request_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  esfa_request_arbiter #(.NUM_REQ(NUM_REQ), .RESULT_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       mut;
    logic [7:0] idx;
    logic [7:0] val;
    logic [7:0] meta;
    logic       ism;
    logic [7:0] sel;
    logic       rb;
    logic [7:0] rv;
    int         t;
  } op_t;

  op_t exp_q[$];
  op_t iss_q[$];
  op_t rsp_q[$];
  op_t cur_x, cur_i, cur_r, tmp;

  logic       s_mut[NUM_REQ];
  logic [7:0] s_idx[NUM_REQ];
  logic [7:0] s_val[NUM_REQ];
  logic [7:0] s_meta[NUM_REQ];
  logic       s_ism[NUM_REQ];
  logic [7:0] s_sel[NUM_REQ];

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int xfer_cnt = 0;
  int res_cyc  = -1;
  logic [7:0] res_sel = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no matching expectation or bound expired (cycle %0d)", name, cyc);
  endtask

  // ESFA datapath model.
  initial begin
    bus.esfa_result_bool  = 1'b0;
    bus.esfa_result_value = 8'hEE;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == res_cyc) begin
        bus.esfa_result_bool  = res_sel[0];
        bus.esfa_result_value = res_sel ^ 8'h2F;
      end else begin
        bus.esfa_result_bool  = 1'b0;
        bus.esfa_result_value = 8'hEE;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.esfa_issue) begin
      res_cyc = cyc + RL;
      res_sel = bus.esfa_selector;
    end
  end

  // Monitors.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.busy) chk("ready_while_busy", 32'(bus.req_ready), 32'd0);

      if (|(bus.req_valid & bus.req_ready)) begin
        xfer_cnt++;
        if (exp_q.size() == 0) fail("unexpected_transfer");
        else begin
          cur_x = exp_q.pop_front();
          chk("grant", 32'(bus.req_ready), 32'(1 << cur_x.id));
          cur_x.t = cyc;
          iss_q.push_back(cur_x);
          rsp_q.push_back(cur_x);
        end
      end

      if (bus.esfa_issue) begin
        if (iss_q.size() == 0) fail("unexpected_issue");
        else begin
          cur_i = iss_q.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(cur_i.t + 1));
          chk("esfa_new_index", 32'(bus.esfa_new_index), 32'(cur_i.idx));
          chk("esfa_new_value", 32'(bus.esfa_new_value), 32'(cur_i.val));
          chk("esfa_metadata", 32'(bus.esfa_metadata), 32'(cur_i.meta));
          chk("esfa_is_metadata", 32'(bus.esfa_is_metadata), 32'(cur_i.ism));
          chk("esfa_selector", 32'(bus.esfa_selector), 32'(cur_i.sel));
          chk("esfa_write_en", 32'(bus.esfa_write_en), 32'(cur_i.mut));
        end
      end else if (bus.esfa_write_en) begin
        fail("write_en_without_issue");
      end

      if (|bus.rsp_valid) begin
        if (rsp_q.size() == 0) fail("unexpected_rsp");
        else begin
          cur_r = rsp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(cur_r.t + 2 + RL));
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << cur_r.id));
          chk("rsp_bool", 32'(bus.rsp_bool), 32'(cur_r.rb));
          chk("rsp_value", 32'(bus.rsp_value), 32'(cur_r.rv));
        end
      end
    end
  end

  task automatic set_slot(input int s, input logic mut, input logic [7:0] idx,
                          input logic [7:0] val, input logic [7:0] meta,
                          input logic ism, input logic [7:0] sel);
    s_mut[s] = mut; s_idx[s] = idx; s_val[s] = val;
    s_meta[s] = meta; s_ism[s] = ism; s_sel[s] = sel;
    bus.req_mutate[s]          = mut;
    bus.req_index[8*s +: 8]    = idx;
    bus.req_value[8*s +: 8]    = val;
    bus.req_metadata[8*s +: 8] = meta;
    bus.req_is_metadata[s]     = ism;
    bus.req_selector[8*s +: 8] = sel;
  endtask

  task automatic expect_op(input int s, input logic rb, input logic [7:0] rv);
    tmp.id = s; tmp.mut = s_mut[s]; tmp.idx = s_idx[s]; tmp.val = s_val[s];
    tmp.meta = s_meta[s]; tmp.ism = s_ism[s]; tmp.sel = s_sel[s];
    tmp.rb = rb; tmp.rv = rv; tmp.t = 0;
    exp_q.push_back(tmp);
  endtask

  // Returns #1 after the posedge that ends the n-th transfer cycle.
  task automatic wait_xfers(input int n);
    int target;
    bit done;
    target = xfer_cnt + n;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk);
      if (xfer_cnt >= target) done = 1;
    end
    #1;
    if (!done) fail("wait_transfer_timeout");
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk); #1;
      if (!bus.busy) done = 1;
    end
    if (!done) fail("wait_idle_timeout");
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_issue"}, 32'(bus.esfa_issue), 32'd0);
    chk({tag, "_write_en"}, 32'(bus.esfa_write_en), 32'd0);
    chk({tag, "_operands"}, {bus.esfa_new_index, bus.esfa_new_value, bus.esfa_metadata, bus.esfa_selector}, 32'd0);
    chk({tag, "_is_metadata"}, 32'(bus.esfa_is_metadata), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp"}, {23'd0, bus.rsp_bool, bus.rsp_value}, 32'd0);
  endtask

  task automatic load_rr_slots();
    for (int i = 0; i < NUM_REQ; i++)
      set_slot(i, 1'b0, 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i), i[0], 8'(8'h10 + i));
  endtask

  initial begin
    bus.req_valid = '0; bus.req_mutate = '0; bus.req_is_metadata = '0;
    bus.req_index = '0; bus.req_value = '0; bus.req_metadata = '0; bus.req_selector = '0;
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // 1: single query from req1, pointer 0 -> 1 granted, pointer becomes 2.
    set_slot(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h05);
    expect_op(1, 1'b1, 8'h2A);
    bus.req_valid = 4'b0010;
    wait_xfers(1);
    bus.req_valid = '0;
    wait_idle();

    // 2: mutate from req0, ack with zeroed result; pointer becomes 1.
    set_slot(0, 1'b1, 8'h03, 8'h11, 8'h00, 1'b0, 8'h77);
    expect_op(0, 1'b0, 8'h00);
    bus.req_valid = 4'b0001;
    wait_xfers(1);
    bus.req_valid = '0;
    wait_idle();

    // 3: all valid from pointer 1 -> 1,2,3,0,1; then pointer 2 with req0/req3 -> 3,0.
    load_rr_slots();
    expect_op(1, 1'b1, 8'h3E);
    expect_op(2, 1'b0, 8'h3D);
    expect_op(3, 1'b1, 8'h3C);
    expect_op(0, 1'b0, 8'h3F);
    expect_op(1, 1'b1, 8'h3E);
    bus.req_valid = 4'b1111;
    wait_xfers(5);
    bus.req_valid = '0;
    wait_idle();
    expect_op(3, 1'b1, 8'h3C);
    expect_op(0, 1'b0, 8'h3F);
    bus.req_valid = 4'b1001;
    wait_xfers(2);
    bus.req_valid = '0;
    wait_idle();

    // 4: req2 changes operands after transfer while still valid; the op
    // in flight keeps the transfer-time values, the re-grant uses the new ones.
    set_slot(2, 1'b0, 8'h5A, 8'h5B, 8'h5C, 1'b1, 8'h33);
    expect_op(2, 1'b1, 8'h1C);
    bus.req_valid = 4'b0100;
    wait_xfers(1);
    set_slot(2, 1'b0, 8'hA5, 8'hB5, 8'hC5, 1'b0, 8'hC2);
    expect_op(2, 1'b0, 8'hED);
    wait_xfers(1);
    bus.req_valid = '0;
    wait_idle();

    // 5: reset during WAIT drops the op; afterwards the pointer restarts at 0.
    set_slot(1, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 8'h01);
    expect_op(1, 1'b1, 8'h2E);
    bus.req_valid = 4'b0010;
    wait_xfers(1);
    bus.req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_q.delete();
    @(posedge clk); #1;
    check_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    load_rr_slots();
    expect_op(0, 1'b0, 8'h3F);
    bus.req_valid = 4'b1111;
    wait_xfers(1);
    bus.req_valid = '0;
    wait_idle();

    // 6: 20 idle cycles, pointer stays at 1 -> req0/req2 valid grants 2 then 0.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_issue", 32'(bus.esfa_issue), 32'd0);
    end
    expect_op(2, 1'b0, 8'h3D);
    expect_op(0, 1'b0, 8'h3F);
    bus.req_valid = 4'b0101;
    wait_xfers(2);
    bus.req_valid = '0;
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("iss_q_drained", 32'(iss_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
